buscador_instrucoes: RTL



---
 rtl/buscador_instrucoes_pkg.sv | 27 ++
 rtl/buscador_instrucoes_memoria.sv | 25 ++
 rtl/buscador_instrucoes.sv | 129 ++++++++++++
 3 files changed

// File: rtl/buscador_instrucoes_pkg.sv
// Shared definitions for the instruction-fetch stage feeding processador_multiciclo:
// opcode field values, FSM state encoding and the default Done timeout.
package buscador_instrucoes_pkg;

    localparam logic [2:0] OP_MV   = 3'b000;
    localparam logic [2:0] OP_MVI  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_HALT = 3'b111;

    localparam int TIMEOUT_DEFAULT = 15;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_IMMED,
        ST_WAIT,
        ST_HALT,
        ST_ERROR
    } estado_t;

    // Opcode lives in bits [8:6] regardless of the overall word width.
    function automatic logic [2:0] opcode_of(input logic [8:0] word_low);
        return word_low[8:6];
    endfunction

endpackage

// File: rtl/buscador_instrucoes_memoria.sv
// Program memory: register array with combinational read and synchronous write.
// Contents are deliberately not reset so a loaded program survives a reset.
module memoria_instrucoes #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/buscador_instrucoes.sv
// Instruction fetcher: walks program memory with a PC, hands one instruction per
// Run/Done handshake to the processor, and stops on halt, end of memory or timeout.
module buscador_instrucoes
    import buscador_instrucoes_pkg::*;
#(
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              Start,
    input  logic              Done,
    input  logic              Wr_en,
    input  logic [ADDR_W-1:0] Wr_addr,
    input  logic [DATA_W-1:0] Wr_data,
    output logic [DATA_W-1:0] DIN,
    output logic              Run,
    output logic [ADDR_W:0]   PC,
    output logic              Busy,
    output logic              Halted,
    output logic              Error
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    estado_t           state_reg, state_next;
    logic [ADDR_W:0]   pc_reg, pc_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [DATA_W-1:0] word;
    logic [2:0]        opcode;
    logic              past_end;
    logic              mem_we;

    // Program may only be rewritten while nothing is being executed.
    assign mem_we = Wr_en && ((state_reg == ST_IDLE) || (state_reg == ST_HALT) ||
                              (state_reg == ST_ERROR));

    memoria_instrucoes #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_memoria (
        .clk     (Clock),
        .we      (mem_we),
        .wr_addr (Wr_addr),
        .wr_data (Wr_data),
        .rd_addr (pc_reg[ADDR_W-1:0]),
        .rd_data (word)
    );

    assign opcode   = opcode_of(word[8:0]);
    assign past_end = pc_reg[ADDR_W];

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_reg <= ST_IDLE;
            pc_reg    <= '0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        cnt_next   = cnt_reg;
        DIN        = '0;
        Run        = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (Start) begin
                    pc_next    = '0;
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // Halt word and end of memory both stop without issuing anything.
                if (past_end || (opcode == OP_HALT)) begin
                    state_next = ST_HALT;
                end else begin
                    DIN        = word;
                    Run        = 1'b1;
                    pc_next    = pc_reg + (ADDR_W+1)'(1);
                    state_next = (opcode == OP_MVI) ? ST_IMMED : ST_WAIT;
                end
            end
            ST_IMMED: begin
                // An mvi in the last slot has no immediate to supply.
                if (past_end) begin
                    state_next = ST_ERROR;
                end else begin
                    DIN        = word;
                    pc_next    = pc_reg + (ADDR_W+1)'(1);
                    state_next = Done ? ST_ISSUE : ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_next = cnt_reg + CNT_W'(1);
                if (Done) begin
                    state_next = ST_ISSUE;
                end else if (cnt_next == CNT_W'(TIMEOUT)) begin
                    state_next = ST_ERROR;
                end
            end
            ST_HALT, ST_ERROR: begin
                if (Start) begin
                    pc_next    = '0;
                    state_next = ST_ISSUE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
        if (state_next == ST_ISSUE) begin
            cnt_next = '0;
        end
    end

    assign PC     = pc_reg;
    assign Busy   = (state_reg == ST_ISSUE) || (state_reg == ST_IMMED) ||
                    (state_reg == ST_WAIT);
    assign Halted = (state_reg == ST_HALT);
    assign Error  = (state_reg == ST_ERROR);

endmodule
